// File: rtl/decl_pkg.sv
// Shared types, type codes and character classes for the C declaration checker.
package decl_pkg;

  typedef enum logic [2:0] {IDLE, KW, PRE_ID, ID, POST_ID, ERR} state_t;

  localparam logic [1:0] TYPE_NONE = 2'd0;
  localparam logic [1:0] TYPE_INT  = 2'd1;
  localparam logic [1:0] TYPE_CHAR = 2'd2;
  localparam logic [1:0] TYPE_LONG = 2'd3;

  // Longest keyword; a fifth keyword letter can never match anything.
  localparam int KW_MAX_LEN = 4;

  function automatic logic is_ws(input logic [7:0] c);
    return (c == 8'h20) || (c == 8'h09) || (c == 8'h00);
  endfunction

  function automatic logic is_letter(input logic [7:0] c);
    return ((c >= "a") && (c <= "z")) || ((c >= "A") && (c <= "Z")) || (c == "_");
  endfunction

  function automatic logic is_alnum(input logic [7:0] c);
    return is_letter(c) || ((c >= "0") && (c <= "9"));
  endfunction

endpackage

// File: rtl/decl_kw_match.sv
// Incremental matcher for the keywords int/char/long over the current token.
module decl_kw_match
  import decl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       restart,
  input  logic       adv,
  input  logic [7:0] ch,
  output logic       hit,
  output logic [1:0] type_code
);

  // mask bit 0 = int, bit 1 = char, bit 2 = long
  logic [2:0] pos;
  logic [2:0] mask;
  logic [2:0] base_pos;
  logic [2:0] base_mask;
  logic [7:0] exp_i, exp_c, exp_l;
  logic       hit_i, hit_c, hit_l;

  always_comb begin
    base_pos  = restart ? 3'd0 : pos;
    base_mask = restart ? 3'b111 : mask;
    exp_i     = 8'h00;
    exp_c     = 8'h00;
    exp_l     = 8'h00;
    case (base_pos)
      3'd0: begin exp_i = "i"; exp_c = "c"; exp_l = "l"; end
      3'd1: begin exp_i = "n"; exp_c = "h"; exp_l = "o"; end
      3'd2: begin exp_i = "t"; exp_c = "a"; exp_l = "n"; end
      3'd3: begin exp_c = "r"; exp_l = "g"; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pos  <= '0;
      mask <= '0;
    end else if (restart || adv) begin
      mask <= base_mask & {ch == exp_l, ch == exp_c, ch == exp_i};
      pos  <= (base_pos == 3'd7) ? 3'd7 : base_pos + 3'd1;
    end
  end

  always_comb begin
    hit_i     = mask[0] && (pos == 3'd3);
    hit_c     = mask[1] && (pos == 3'd4);
    hit_l     = mask[2] && (pos == 3'd4);
    hit       = hit_i || hit_c || hit_l;
    type_code = hit_i ? TYPE_INT : hit_c ? TYPE_CHAR : hit_l ? TYPE_LONG : TYPE_NONE;
  end

endmodule

// File: rtl/decl_check.sv
// Streaming checker for "TYPE id, id, ...;" declarations, one character per valid beat.
module decl_check
  import decl_pkg::*;
#(
  parameter int MAX_ID_LEN = 8,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in,
  output logic             ok,
  output logic             err,
  output logic [1:0]       decl_type,
  output logic [CNT_W-1:0] id_count
);

  localparam int LEN_CAP = (MAX_ID_LEN > KW_MAX_LEN) ? MAX_ID_LEN : KW_MAX_LEN;
  localparam int LEN_W   = $clog2(LEN_CAP + 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_ID_LEN);
  localparam logic [LEN_W-1:0] KW_LAST  = LEN_W'(KW_MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_FULL = '1;

  state_t           state;
  logic [LEN_W-1:0] len;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       typ;

  logic c_ws, c_letter, c_alnum, c_comma, c_semi;
  logic kw_restart, kw_adv, kw_hit, close_ok;
  logic [1:0] kw_type;

  always_comb begin
    c_ws       = is_ws(in);
    c_letter   = is_letter(in);
    c_alnum    = is_alnum(in);
    c_comma    = (in == ",");
    c_semi     = (in == ";");
    kw_restart = in_valid && reset && c_letter && ((state == IDLE) || (state == PRE_ID));
    kw_adv     = in_valid && reset && (((state == KW) && c_letter) || ((state == ID) && c_alnum));
    close_ok   = !kw_hit && (cnt != CNT_FULL);
  end

  decl_kw_match u_kw (
    .clk       (clk),
    .reset     (reset),
    .restart   (kw_restart),
    .adv       (kw_adv),
    .ch        (in),
    .hit       (kw_hit),
    .type_code (kw_type)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      len       <= '0;
      cnt       <= '0;
      typ       <= TYPE_NONE;
      ok        <= 1'b0;
      err       <= 1'b0;
      decl_type <= TYPE_NONE;
      id_count  <= '0;
    end else begin
      ok  <= 1'b0;
      err <= 1'b0;
      if (in_valid) begin
        case (state)
          IDLE: begin
            if (c_letter) begin
              state <= KW;
              len   <= LEN_W'(1);
            end else if (!(c_ws || c_semi)) begin
              state <= ERR;
            end
          end
          KW: begin
            if (c_letter) begin
              if (len == KW_LAST) state <= ERR;
              else                len   <= len + 1'b1;
            end else if (c_ws) begin
              if (kw_hit) begin
                state <= PRE_ID;
                typ   <= kw_type;
              end else begin
                state <= ERR;
              end
            end else if (c_semi) begin
              err   <= 1'b1;
              state <= IDLE;
            end else begin
              state <= ERR;
            end
          end
          PRE_ID: begin
            if (c_letter) begin
              state <= ID;
              len   <= LEN_W'(1);
            end else if (c_semi) begin
              err   <= 1'b1;
              state <= IDLE;
            end else if (!c_ws) begin
              state <= ERR;
            end
          end
          ID: begin
            if (c_alnum) begin
              if (len == LEN_MAX) state <= ERR;
              else                len   <= len + 1'b1;
            end else if (c_ws || c_comma || c_semi) begin
              if (!close_ok) begin
                if (c_semi) begin
                  err   <= 1'b1;
                  state <= IDLE;
                end else begin
                  state <= ERR;
                end
              end else begin
                cnt <= cnt + 1'b1;
                if (c_ws) begin
                  state <= POST_ID;
                end else if (c_comma) begin
                  state <= PRE_ID;
                end else begin
                  ok        <= 1'b1;
                  decl_type <= typ;
                  id_count  <= cnt + 1'b1;
                  state     <= IDLE;
                end
              end
            end else begin
              state <= ERR;
            end
          end
          POST_ID: begin
            if (c_comma) begin
              state <= PRE_ID;
            end else if (c_semi) begin
              ok        <= 1'b1;
              decl_type <= typ;
              id_count  <= cnt;
              state     <= IDLE;
            end else if (!c_ws) begin
              state <= ERR;
            end
          end
          ERR: begin
            if (c_semi) begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
        // Every ';' outside IDLE ends the statement, so the working context is dropped here.
        if (c_semi && (state != IDLE)) begin
          cnt <= '0;
          typ <= TYPE_NONE;
          len <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_decl_check.sv
// Directed bench for decl_check: default instance plus a CNT_W=2 instance on the same stream.
module tb_decl_check;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in = 8'h00;
  logic       ok, err, ok2, err2;
  logic [1:0] decl_type, decl_type2;
  logic [3:0] id_count;
  logic [1:0] id_count2;

  int checks = 0;
  int errors = 0;
  int ok_seen = 0, err_seen = 0;

  decl_check #(.MAX_ID_LEN(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in),
    .ok(ok), .err(err), .decl_type(decl_type), .id_count(id_count)
  );

  decl_check #(.MAX_ID_LEN(8), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in),
    .ok(ok2), .err(err2), .decl_type(decl_type2), .id_count(id_count2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    ok_seen  <= ok_seen + int'(ok);
    err_seen <= err_seen + int'(err);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string s, input bit gap);
    for (int i = 0; i < s.len(); i++) begin
      in_valid = 1'b1;
      in       = s[i];
      tick();
      if (gap && (i != s.len() - 1)) begin
        in_valid = 1'b0;
        in       = "x";
        tick();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; in = "i";
    tick(); tick();
    reset = 1'b1; in_valid = 1'b0;
    tick();
    checks++; if (ok !== 1'b0) begin errors++; $display("FAIL reset_ok: got %0b want 0", ok); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", err); end
    checks++; if (decl_type !== 2'd0) begin errors++; $display("FAIL reset_type: got %0d want 0", decl_type); end
    checks++; if (id_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", id_count); end
    // The 'i' seen during reset must be dropped, leaving "nt" as a bad keyword.
    send("nt a;", 0);
    checks++; if (err !== 1'b1 || ok !== 1'b0) begin errors++; $display("FAIL reset_ignores_in: got ok=%0b err=%0b want ok=0 err=1", ok, err); end
    tick();
  endtask

  task automatic test_basic();
    int o0;
    o0 = ok_seen;
    send("int a, b;", 0);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_ok: got %0b want 1", ok); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err: got %0b want 0", err); end
    checks++; if (decl_type !== 2'd1) begin errors++; $display("FAIL basic_type: got %0d want 1", decl_type); end
    checks++; if (id_count !== 4'd2) begin errors++; $display("FAIL basic_count: got %0d want 2", id_count); end
    tick();
    checks++; if (ok !== 1'b0) begin errors++; $display("FAIL basic_ok_width: got %0b want 0", ok); end
    checks++; if (ok_seen - o0 !== 1) begin errors++; $display("FAIL basic_pulses: got %0d want 1", ok_seen - o0); end
  endtask

  task automatic test_gaps();
    int o0, e0;
    o0 = ok_seen; e0 = err_seen;
    send("long  x1 ,_y ,z;", 1);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL gaps_ok: got %0b want 1", ok); end
    checks++; if (decl_type !== 2'd3) begin errors++; $display("FAIL gaps_type: got %0d want 3", decl_type); end
    checks++; if (id_count !== 4'd3) begin errors++; $display("FAIL gaps_count: got %0d want 3", id_count); end
    tick();
    checks++; if (ok_seen - o0 !== 1 || err_seen - e0 !== 0) begin errors++; $display("FAIL gaps_pulses: got ok=%0d err=%0d want ok=1 err=0", ok_seen - o0, err_seen - e0); end
  endtask

  task automatic test_invalid();
    string bad [4];
    int o0, e0;
    bad = '{"char int;", "int 1a;", "int a,;", "float f;"};
    for (int i = 0; i < 4; i++) begin
      o0 = ok_seen; e0 = err_seen;
      send(bad[i], 0);
      checks++; if (err !== 1'b1 || ok !== 1'b0) begin errors++; $display("FAIL invalid_%0d_pulse: got ok=%0b err=%0b want ok=0 err=1", i, ok, err); end
      tick();
      checks++; if (decl_type !== 2'd3 || id_count !== 4'd3) begin errors++; $display("FAIL invalid_%0d_hold: got type=%0d count=%0d want type=3 count=3", i, decl_type, id_count); end
      checks++; if (ok_seen - o0 !== 0 || err_seen - e0 !== 1) begin errors++; $display("FAIL invalid_%0d_pulses: got ok=%0d err=%0d want ok=0 err=1", i, ok_seen - o0, err_seen - e0); end
    end
  endtask

  task automatic test_id_len();
    send("int abcdefgh;", 0);
    checks++; if (ok !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL len_max_pulse: got ok=%0b err=%0b want ok=1 err=0", ok, err); end
    checks++; if (decl_type !== 2'd1 || id_count !== 4'd1) begin errors++; $display("FAIL len_max_out: got type=%0d count=%0d want type=1 count=1", decl_type, id_count); end
    tick();
    send("int abcdefghi;", 0);
    checks++; if (err !== 1'b1 || ok !== 1'b0) begin errors++; $display("FAIL len_over_pulse: got ok=%0b err=%0b want ok=0 err=1", ok, err); end
    checks++; if (id_count !== 4'd1) begin errors++; $display("FAIL len_over_hold: got %0d want 1", id_count); end
    tick();
  endtask

  task automatic test_count_limit();
    send("int a,b,c;", 0);
    checks++; if (ok2 !== 1'b1 || err2 !== 1'b0) begin errors++; $display("FAIL cnt_full_pulse: got ok=%0b err=%0b want ok=1 err=0", ok2, err2); end
    checks++; if (id_count2 !== 2'd3) begin errors++; $display("FAIL cnt_full_count: got %0d want 3", id_count2); end
    tick();
    send("int a,b,c,d;", 0);
    checks++; if (err2 !== 1'b1 || ok2 !== 1'b0) begin errors++; $display("FAIL cnt_over_pulse: got ok=%0b err=%0b want ok=0 err=1", ok2, err2); end
    checks++; if (id_count2 !== 2'd3) begin errors++; $display("FAIL cnt_over_hold: got %0d want 3", id_count2); end
    checks++; if (ok !== 1'b1 || id_count !== 4'd4) begin errors++; $display("FAIL cnt_wide_inst: got ok=%0b count=%0d want ok=1 count=4", ok, id_count); end
    tick();
  endtask

  task automatic test_prefix();
    send("char in, inta, lon;", 0);
    checks++; if (ok !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL prefix_pulse: got ok=%0b err=%0b want ok=1 err=0", ok, err); end
    checks++; if (decl_type !== 2'd2 || id_count !== 4'd3) begin errors++; $display("FAIL prefix_out: got type=%0d count=%0d want type=2 count=3", decl_type, id_count); end
    tick();
  endtask

  task automatic test_back_to_back();
    int o0;
    o0 = ok_seen;
    send("int a;", 0);
    checks++; if (ok !== 1'b1 || decl_type !== 2'd1 || id_count !== 4'd1) begin errors++; $display("FAIL b2b_first: got ok=%0b type=%0d count=%0d want ok=1 type=1 count=1", ok, decl_type, id_count); end
    send("long b;", 0);
    checks++; if (ok !== 1'b1 || decl_type !== 2'd3 || id_count !== 4'd1) begin errors++; $display("FAIL b2b_second: got ok=%0b type=%0d count=%0d want ok=1 type=3 count=1", ok, decl_type, id_count); end
    tick();
    checks++; if (ok !== 1'b0) begin errors++; $display("FAIL b2b_idle_low: got %0b want 0", ok); end
    checks++; if (ok_seen - o0 !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", ok_seen - o0); end
  endtask

  task automatic test_reset_mid();
    int o0, e0;
    send("char q", 0);
    o0 = ok_seen; e0 = err_seen;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++; if (ok !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL midrst_pulse: got ok=%0b err=%0b want 0 0", ok, err); end
    checks++; if (decl_type !== 2'd0 || id_count !== 4'd0) begin errors++; $display("FAIL midrst_out: got type=%0d count=%0d want 0 0", decl_type, id_count); end
    send("int z;", 0);
    checks++; if (ok !== 1'b1 || decl_type !== 2'd1 || id_count !== 4'd1) begin errors++; $display("FAIL midrst_next: got ok=%0b type=%0d count=%0d want ok=1 type=1 count=1", ok, decl_type, id_count); end
    tick();
    checks++; if (ok_seen - o0 !== 1 || err_seen - e0 !== 0) begin errors++; $display("FAIL midrst_pulses: got ok=%0d err=%0d want ok=1 err=0", ok_seen - o0, err_seen - e0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_invalid();
    test_id_len();
    test_count_limit();
    test_prefix();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decl_check.md
# decl_check

Streaming checker for C-style variable declarations, one ASCII character per accepted beat. Successor to the single-keyword `int` checker in the P1 character-stream family. It adds:

- three type keywords;
- a valid-qualified input;
- a parametrised identifier length limit;
- a separate error pulse;
- reporting of the declared type and the identifier count.

It sits after the character source and drives the pass/fail scoreboard.

## Interface
- `MAX_ID_LEN`, default 8: maximum identifier length in characters, ≥1.
- `CNT_W`, default 4: width of the identifier counter. At most 2^CNT_W−1 identifiers per statement.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-low reset.
- `in_valid` in 1: `in` carries a character this cycle.
- `in` in 8: ASCII character.
- `ok` out 1: one-cycle pulse, a valid declaration was terminated by `;`.
- `err` out 1: one-cycle pulse, an invalid statement was terminated by `;`.
- `decl_type` out 2: type of the last valid declaration. 1=int, 2=char, 3=long, 0 none.
- `id_count` out CNT_W: number of identifiers in the last valid declaration.

## Operation
- Character classes:
  - ws = space, tab, NUL.
  - letter = a–z, A–Z, `_`.
  - alnum = letter or 0–9.
- Grammar: ws* TYPE ws+ ID (ws* `,` ws* ID)* ws* `;`.
  - TYPE ∈ {int, char, long}, lower case only.
  - ID = letter alnum*, length 1..MAX_ID_LEN.
  - ID must not equal any TYPE keyword.
- States and transitions on an accepted beat (`in_valid`=1):
  - IDLE:
    - ws or `;` → IDLE, no pulse.
    - letter → KW.
    - other → ERR.
  - KW:
    - letter → KW. More than 4 letters → ERR.
    - ws → PRE_ID if the letters exactly match a keyword (latch type), else ERR.
    - `;` → err, IDLE.
    - other → ERR.
  - PRE_ID:
    - ws → PRE_ID.
    - letter → ID, with len=1 and keyword tracker restarted.
    - `;` → err, IDLE. Covers "int ;" and "int a,;".
    - other → ERR.
  - ID:
    - alnum → ID, len+1. If len would exceed MAX_ID_LEN → ERR.
    - ws / `,` / `;` first close the ID. The close fails (→ ERR, or err+IDLE on `;`) if the ID equals a keyword or the count is already at 2^CNT_W−1. Otherwise the count increments.
    - After a successful close: ws → POST_ID, `,` → PRE_ID, `;` → ok, IDLE.
    - other → ERR.
  - POST_ID:
    - ws → POST_ID.
    - `,` → PRE_ID.
    - `;` → ok, IDLE.
    - other → ERR.
  - ERR:
    - `;` → err, IDLE.
    - else → ERR.
- On an ok terminator, `decl_type` and `id_count` load the statement's latched type and final count. On an err terminator they hold their previous values.
- The working count and type clear on every return to IDLE.
- A beat with `in_valid`=0 changes no state.

## Timing
- Outputs are registered. `ok`/`err` go high in the cycle after the edge that accepted `;`, and are high for exactly one cycle.
- `ok` and `err` are never high together.
- Back-to-back statements are legal. A `;` immediately followed by `i` starts the next KW with no idle beat.
- A cycle with `in_valid`=0 forces `ok`/`err` to 0 for the following cycle.
- Reset: when `reset`=0 at an edge:
  - state goes to IDLE;
  - `ok`, `err`, `decl_type`, `id_count` and all internal counters go to 0;
  - `in` is ignored on that edge.
- Reset mid-statement discards the partial statement and emits no pulse.
- Identifier of exactly MAX_ID_LEN characters is legal; MAX_ID_LEN+1 is an error.
- Keyword prefixes or extensions are legal identifiers: "in", "inta", "lon".

## Structure
- Shared package `decl_pkg`:
  - state enum (IDLE, KW, PRE_ID, ID, POST_ID, ERR);
  - type codes TYPE_NONE/INT/CHAR/LONG;
  - character-class functions `is_ws`, `is_letter`, `is_alnum`.
- Sub-module `decl_kw_match`:
  - tracks position and candidate mask for int/char/long;
  - restarted at the start of each token;
  - outputs `hit` and `type_code` for the characters seen so far.
  - Instantiated once and shared by KW and ID, since only one token is active at a time.

## Test plan
- "int a, b;" on consecutive beats → `ok`=1 one cycle after `;`, `decl_type`=1, `id_count`=2, `err`=0.
- "long  x1 ,_y ,z;" with `in_valid` gaps inserted between characters → `ok`=1 once, `decl_type`=3, `id_count`=3. Gaps change no state.
- Invalid statements, each → `err` pulse, `decl_type`/`id_count` unchanged from the prior ok:
  - "char int;"
  - "int 1a;"
  - "int a,;"
  - "float f;"
- With MAX_ID_LEN=8:
  - "int abcdefgh;" → `ok`, `id_count`=1.
  - "int abcdefghi;" → `err`.
- With CNT_W=2:
  - "int a,b,c;" → `ok`, `id_count`=3.
  - "int a,b,c,d;" → `err`.
- Reset mid-statement: "char q" then `reset`=0 one cycle, then "int z;" → no pulse for the aborted statement, all outputs 0 after reset, then `ok` with `decl_type`=1, `id_count`=1.
